// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
package store_buffer_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [29:0] waddr;
    logic [31:0] data;
  } entry_t;

  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/stb_match.sv
// Compares a load word index against every live buffer entry; reports the youngest hit.
module stb_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  entry_t            entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [29:0]       ld_widx,
  output logic              hit,
  output logic [31:0]       hit_data
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((PTR_W+1)'(k) < count && entries[idx].waddr == ld_widx) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of DM; also owns DM's address mux (drain vs. load).
// Define STORE_BUFFER_FWD_EN to forward matching stores to loads instead of stalling.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_pc,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic [31:0] dm_pc,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_memwrite,
  input  logic [31:0] dm_rdata,
  output logic        empty
);

  entry_t           entries [DEPTH];
  entry_t           head_e;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, enq, drn, hit;
  logic [31:0]      hit_data;

  stb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .entries  (entries),
    .head     (head_q),
    .count    (count_q),
    .ld_widx  (word_idx(ld_addr)),
    .hit      (hit),
    .hit_data (hit_data)
  );

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign enq      = st_valid && st_ready;
  assign drn      = !empty && (!ld_valid || full || hit);
  assign head_e   = entries[head_q];

  always_comb begin
    count_d = count_q;
    unique case ({enq, drn})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (drn) head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) entries[tail_q] <= '{pc: st_pc, waddr: word_idx(st_addr), data: st_wdata};
  end

  always_comb begin
    dm_memwrite = 1'b0;
    dm_pc       = '0;
    dm_addr     = ld_addr;
    dm_wdata    = '0;
    if (drn) begin
      // Gated by reset so pending stores never reach DM on the reset edge.
      dm_memwrite = !reset;
      dm_pc       = head_e.pc;
      dm_addr     = {head_e.waddr, 2'b00};
      dm_wdata    = head_e.data;
    end
  end

  always_comb begin
    ld_data  = dm_rdata;
    ld_stall = 1'b0;
    if (ld_valid) begin
`ifdef STORE_BUFFER_FWD_EN
      if (hit) begin
        ld_data = hit_data;
      end else if (drn) begin
        ld_stall = 1'b1;
      end
`else
      // Any drain while a load is pending means full or a hit: hold the load.
      if (drn) ld_stall = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer with a small DM word-memory model.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready, ld_valid, ld_stall, dm_memwrite, empty;
  logic [31:0] st_pc, st_addr, st_wdata, ld_addr, ld_data;
  logic [31:0] dm_pc, dm_addr, dm_wdata, dm_rdata;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_pc       (st_pc),
    .st_addr     (st_addr),
    .st_wdata    (st_wdata),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_stall    (ld_stall),
    .dm_pc       (dm_pc),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_memwrite (dm_memwrite),
    .dm_rdata    (dm_rdata),
    .empty       (empty)
  );

  // DM model: async read, write on the rising edge.
  logic [31:0] dmem [256];
  int          wr_count = 0;
  assign dm_rdata = dmem[dm_addr[9:2]];
  always @(posedge clk) begin
    if (dm_memwrite) begin
      dmem[dm_addr[9:2]] <= dm_wdata;
      wr_count <= wr_count + 1;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        stv;
    logic [31:0] pc, addr, data;
    logic        ldv;
    logic [31:0] lda;
    logic        e_ready, e_stall, e_wr, e_empty;
    logic [31:0] e_dmaddr, e_dmpc;
    logic        ld_chk;
    logic [31:0] e_lddata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic stv, input logic [31:0] pc, input logic [31:0] addr,
                              input logic [31:0] data, input logic ldv, input logic [31:0] lda,
                              input logic e_ready, input logic e_stall, input logic e_wr,
                              input logic e_empty, input logic [31:0] e_dmaddr,
                              input logic [31:0] e_dmpc, input logic ld_chk,
                              input logic [31:0] e_lddata);
    vec_t v;
    v.stv = stv; v.pc = pc; v.addr = addr; v.data = data; v.ldv = ldv; v.lda = lda;
    v.e_ready = e_ready; v.e_stall = e_stall; v.e_wr = e_wr; v.e_empty = e_empty;
    v.e_dmaddr = e_dmaddr; v.e_dmpc = e_dmpc; v.ld_chk = ld_chk; v.e_lddata = e_lddata;
    return v;
  endfunction

  task automatic drive(input logic stv, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] data, input logic ldv, input logic [31:0] lda);
    st_valid = stv; st_pc = pc; st_addr = addr; st_wdata = data;
    ld_valid = ldv; ld_addr = lda;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] exp_a;
    int          stalls;
    int          wr_snap;

    for (int i = 0; i < 256; i++) dmem[i] = 32'hD000_0000 + 32'(i);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Single store drain, then fill to full under a non-matching load.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 1, 32'hD000_0000));
    tbl.push_back(mk(1, 32'h3000, 32'h10, 32'hAAAA_5555, 0, 0,
                     1, 0, 0, 1, 32'h0, 0, 1, 32'hD000_0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h10, 32'h3000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 1, 32'hD000_0000));
    tbl.push_back(mk(1, 32'h100, 32'h20, 32'hC1, 1, 32'h40, 1, 0, 0, 1, 32'h40, 0, 1,
                     32'hD000_0010));
    tbl.push_back(mk(1, 32'h104, 32'h24, 32'hC2, 1, 32'h40, 1, 0, 0, 0, 32'h40, 0, 1,
                     32'hD000_0010));
    tbl.push_back(mk(1, 32'h108, 32'h28, 32'hC3, 1, 32'h40, 1, 0, 0, 0, 32'h40, 0, 1,
                     32'hD000_0010));
    tbl.push_back(mk(1, 32'h10C, 32'h2C, 32'hC4, 1, 32'h40, 1, 0, 0, 0, 32'h40, 0, 1,
                     32'hD000_0010));
    tbl.push_back(mk(1, 32'h110, 32'h30, 32'hC5, 1, 32'h40, 0, 1, 1, 0, 32'h20, 32'h100, 0, 0));
    tbl.push_back(mk(1, 32'h110, 32'h30, 32'hC5, 1, 32'h40, 1, 0, 0, 0, 32'h40, 0, 1,
                     32'hD000_0010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h24, 32'h104, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h28, 32'h108, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h2C, 32'h10C, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h30, 32'h110, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 1, 32'hD000_0000));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].stv, tbl[i].pc, tbl[i].addr, tbl[i].data, tbl[i].ldv, tbl[i].lda);
      #1;
      check($sformatf("v%0d st_ready", i), 32'(st_ready), 32'(tbl[i].e_ready));
      check($sformatf("v%0d ld_stall", i), 32'(ld_stall), 32'(tbl[i].e_stall));
      check($sformatf("v%0d dm_memwrite", i), 32'(dm_memwrite), 32'(tbl[i].e_wr));
      check($sformatf("v%0d empty", i), 32'(empty), 32'(tbl[i].e_empty));
      check($sformatf("v%0d dm_addr", i), dm_addr, tbl[i].e_dmaddr);
      check($sformatf("v%0d dm_pc", i), dm_pc, tbl[i].e_dmpc);
      if (tbl[i].ld_chk) check($sformatf("v%0d ld_data", i), ld_data, tbl[i].e_lddata);
    end
    check("dm word 0x10", dmem[4], 32'hAAAA_5555);
    for (int i = 0; i < 5; i++)
      check($sformatf("dm word 0x%0h", 32 + 4 * i), dmem[8 + i], 32'hC1 + 32'(i));

    // Two stores to the same word, then a load of it.
    do_reset();
    @(negedge clk); drive(1, 32'h200, 32'h8, 32'h11, 1, 32'h40);
    @(negedge clk); drive(1, 32'h204, 32'h8, 32'h22, 1, 32'h40);
    @(negedge clk); drive(0, 0, 0, 0, 1, 32'h8);
    #1;
`ifdef STORE_BUFFER_FWD_EN
    check("fwd ld_data", ld_data, 32'h22);
    check("fwd ld_stall", 32'(ld_stall), 32'h0);
`else
    stalls = 0;
    while (ld_stall && stalls < 8) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check("nofwd stall cycles", 32'(stalls), 32'd2);
    check("nofwd ld_data", ld_data, 32'h22);
    check("nofwd ld_stall", 32'(ld_stall), 32'h0);
`endif

    // Steady enqueue+drain at count 2 across three laps.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1, 32'h400 + 32'(i), 32'h80 + 32'(4 * i), 32'h500 + 32'(i), 1, 32'h3FC);
      exp_q.push_back(32'h80 + 32'(4 * i));
    end
    for (int i = 2; i < 2 + 3 * DEPTH; i++) begin
      @(negedge clk);
      drive(1, 32'h400 + 32'(i), 32'h80 + 32'(4 * i), 32'h500 + 32'(i), 0, 0);
      exp_q.push_back(32'h80 + 32'(4 * i));
      #1;
      exp_a = exp_q.pop_front();
      check($sformatf("lap%0d memwrite", i), 32'(dm_memwrite), 32'h1);
      check($sformatf("lap%0d dm_addr", i), dm_addr, exp_a);
      check($sformatf("lap%0d st_ready", i), 32'(st_ready), 32'h1);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      exp_a = exp_q.pop_front();
      check($sformatf("tail%0d dm_addr", i), dm_addr, exp_a);
    end
    @(negedge clk);
    #1;
    check("lap empty", 32'(empty), 32'h1);
    check("lap memwrite", 32'(dm_memwrite), 32'h0);
    check("lap last data", dmem[(32'h80 + 32'(4 * 13)) >> 2], 32'h500 + 32'd13);

    // Reset while three stores are pending.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 32'h600, 32'hC0 + 32'(4 * i), 32'hEE + 32'(i), 1, 32'h3FC);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    wr_snap = wr_count;
    #1;
    check("rst memwrite", 32'(dm_memwrite), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst empty", 32'(empty), 32'h1);
    check("rst st_ready", 32'(st_ready), 32'h1);
    repeat (5) @(negedge clk);
    check("rst no writes", 32'(wr_count), 32'(wr_snap));
    check("rst word 0xC0", dmem[32'hC0 >> 2], 32'hD000_0030);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipeline's memory stage and the DM word memory.
- Accepts word stores in one cycle and retires them into DM in FIFO order, one per cycle, whenever DM's single address port is free.
- Also owns DM's address mux, arbitrating between buffered stores (drain) and pipeline loads.
- Carries each store's pc through so DM's write log still reports the originating instruction.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); count register is PTR_W+1 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  memory stage presents a store
- st_ready  out  1  buffer can accept a store this cycle
- st_pc  in  32  pc of the store instruction
- st_addr  in  32  byte address; word index is bits [31:2]
- st_wdata  in  32  store data
- ld_valid  in  1  memory stage presents a load
- ld_addr  in  32  load byte address
- ld_data  out  32  load result: forwarded entry or dm_rdata
- ld_stall  out  1  load cannot complete this cycle; stage must hold
- dm_pc  out  32  to DM pc
- dm_addr  out  32  to DM Addr
- dm_wdata  out  32  to DM WriteData
- dm_memwrite  out  1  to DM MemWrite
- dm_rdata  in  32  from DM ReadData
- empty  out  1  no pending stores; used by halt/sync logic

Behaviour:
- Storage: DEPTH entries {pc, addr[31:2], data}, head/tail pointers (wrap mod DEPTH), count.
- Reset: pointers and count cleared, entry contents don't-care. Outputs: st_ready=1, empty=1, dm_memwrite=0, ld_stall=0.
- Enqueue:
  - st_ready = (count != DEPTH). No combinational dependence on drain.
  - st_valid && st_ready writes the entry at tail on the clock edge; tail increments.
- Drain request drn:
  - Asserted when count != 0 and any of:
    - ld_valid == 0;
    - count == DEPTH;
    - the load matches a buffered entry.
  - When drn: dm_memwrite=1 and dm_pc/dm_addr/dm_wdata take the head entry (dm_addr = {head.addr, 2'b00}). Head increments at the edge. DM commits on the same edge, so latency from enqueue to DM write is at least 1 cycle.
  - When not drn: dm_addr = ld_addr, dm_memwrite=0, dm_pc/dm_wdata = 0.
- Count update:
  - Enqueue only: +1.
  - Drain only: -1.
  - Both in the same cycle: unchanged, both pointers advance.
- Match: ld_addr[31:2] equals addr of any valid entry (a valid entry lies between head and tail per count). Entries are never coalesced; duplicates are allowed.
- Load without a match:
  - If not drn: ld_data = dm_rdata, ld_stall = 0.
  - If full (count == DEPTH): drain has priority, ld_stall = 1.
- Load with a match: see Optional Feature.
- A store enqueued in the same cycle as a load is not visible to that load. The pipeline orders them itself.
- ld_valid == 0: ld_stall = 0, ld_data = dm_rdata.
- empty = (count == 0), combinational.
- reset mid-drain discards all pending stores. No DM write occurs on the reset edge because dm_memwrite is forced to 0 while reset is high.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined:
  - A matching load takes ld_data from the youngest matching entry (closest to tail).
  - ld_stall = 0 unless full-and-drain forces a stall and the load misses. A hit is served even while draining.
- Undefined:
  - A matching load asserts ld_stall = 1 and drains.
  - It stalls each cycle until no entry matches, then reads DM.

Decomposition:
- Package store_buffer_pkg:
  - entry typedef {pc[31:0], waddr[29:0], data[31:0]};
  - DEPTH_DEFAULT;
  - function word_idx(addr) returning addr[31:2].
- One sub-module, stb_match:
  - Combinational DEPTH-way comparator plus youngest-hit priority select.
  - Inputs: entries, head, count, ld word index.
  - Outputs: hit, hit_data.

Test Plan:
- reset, then store (pc=0x3000, addr=0x10, data=0xAAAA5555) with ld_valid=0 -> next cycle dm_memwrite=1, dm_addr=0x10, dm_pc=0x3000; empty=1 after the edge.
- Four stores with ld_valid held high at non-matching 0x40 -> st_ready=0 after the 4th; ld_stall=1 and drain starts; the fifth store is accepted the cycle after count drops to 3.
- FWD_EN: stores 0x11 then 0x22 to addr 0x8, then load 0x8 -> ld_data=0x22, ld_stall=0, same cycle.
- FWD off: same sequence -> ld_stall=1 for 2 drain cycles, then ld_data=dm_rdata=0x22.
- Simultaneous enqueue and drain at count=2 -> count stays 2; pointers wrap correctly across 3 full laps of DEPTH.
- reset asserted with count=3 -> dm_memwrite=0 that edge; afterwards empty=1, st_ready=1, and no later DM write of old data.
